// File: rtl/uart_flash_rx_if.sv
// Byte-stream port bundle between the UART receiver and the flash write/read path.
interface uart_flash_rx_if;
  logic        en;
  logic        rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [31:0] rx_byte_num;
  logic        rx_done;

  modport master (
    output en, rxd,
    input  rx_data, rx_valid, frame_err, rx_byte_num, rx_done
  );

  modport slave (
    input  en, rxd,
    output rx_data, rx_valid, frame_err, rx_byte_num, rx_done
  );
endinterface

// File: rtl/uart_flash_rx.sv
// 8N1 UART receiver feeding the flash writer, with byte count and idle-line timeout.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_flash_rx #(
  parameter int unsigned CLKS_PER_BIT      = 434,
  parameter int unsigned IDLE_TIMEOUT_BITS = 32
) (
  input logic           clk,
  input logic           rst,
  uart_flash_rx_if.slave bus
);

  localparam int unsigned TW = 16;
  localparam int unsigned IW = 24;
  localparam logic [TW-1:0] HALF    = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] TO_LAST = IW'(IDLE_TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q, rxs_prev_q, en_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic          par_q, par_d;
  logic          perr;
  logic          fall, en_rise;

  assign fall    = rxs_prev_q & ~rxs_q;
  assign en_rise = bus.en & ~en_q;

  // Two-flop synchronizer plus edge-detect history; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      en_q       <= 1'b0;
    end else begin
      rx_meta_q  <= bus.rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      en_q       <= bus.en;
    end
  end

  always_comb begin
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = ^{sh_q, par_q};
`endif
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cnt_d   = cnt_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (bus.en && fall) state_d = S_START;
      end
      S_START: begin
        if (tmr_q == HALF) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tmr_q == LAST) begin
          tmr_d = '0;
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tmr_q == LAST) begin
          tmr_d   = '0;
          par_d   = rxs_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tmr_q == LAST) begin
          tmr_d = '0;
          if (rxs_q && !perr) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
          end else begin
            ferr_d = 1'b1;
          end
          // A low stop bit may be a break; wait for the line to recover first.
          state_d = rxs_q ? S_IDLE : S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!bus.en) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      data_d  = data_q;
      cnt_d   = cnt_q;
    end
    if (en_rise) cnt_d = '0;
  end

  // Idle counter measures line-idle time from the IDLE entry after the last good byte.
  always_comb begin
    idle_d  = idle_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      idle_d = '0;
    end else if (rxs_q) begin
      if (idle_q != '1) idle_d = idle_q + IW'(1);
      if (armed_q && idle_q == TO_LAST) begin
        done_d  = 1'b1;
        armed_d = 1'b0;
      end
    end
    if (valid_d) armed_d = 1'b1;
    if (en_rise) armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      idle_q  <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      idle_q  <= idle_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.rx_byte_num = cnt_q;
  assign bus.rx_done     = done_q;

endmodule
